mem_rr_arb: RTL and testbench

//  N-port round-robin arbiter that shares one valid/ready memory master bus between NUM_PORTS requesters (CPU ifetch, CPU data, DMA, debug).

---
 rtl/mem_rr_arb_if.sv | 28 ++
 rtl/mem_rr_arb.sv | 129 ++++++++++++
 tb/tb_mem_rr_arb.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arb_if.sv
// Requester-side and memory-side valid/ready signals of the round-robin memory arbiter.
// The arbiter connects through the master modport; the surrounding system uses the slave modport.
interface mem_rr_arb_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]    s_valid;
  logic [NUM_PORTS-1:0]    s_ready;
  logic [32*NUM_PORTS-1:0] s_addr;
  logic [32*NUM_PORTS-1:0] s_wdata;
  logic [4*NUM_PORTS-1:0]  s_wstrb;
  logic [31:0]             s_rdata;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;
  logic [3:0]              mem_wstrb;
  logic [31:0]             mem_rdata;

  modport master (
    input  s_valid, s_addr, s_wdata, s_wstrb, mem_ready, mem_rdata,
    output s_ready, s_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output s_valid, s_addr, s_wdata, s_wstrb, mem_ready, mem_rdata,
    input  s_ready, s_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_rr_arb.sv
// Round-robin arbiter sharing one valid/ready memory bus between NUM_PORTS requesters,
// with bubble-free back-to-back grants and a bus timeout that aborts a stuck access.
module mem_rr_arb #(
  parameter int          NUM_PORTS  = 4,
  parameter int          TIMEOUT    = 64,
  parameter logic [31:0] ABORT_DATA = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rstn,
  mem_rr_arb_if.master                 bus,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_id,
  output logic                         busy,
  output logic                         timeout_err
);
  localparam int GW = $clog2(NUM_PORTS);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] TMR_MAX  = '1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [31:0]     addr_a  [NUM_PORTS];
  logic [31:0]     wdata_a [NUM_PORTS];
  logic [3:0]      wstrb_a [NUM_PORTS];

  logic [NUM_PORTS-1:0] gnt_oh;
  logic [NUM_PORTS-1:0] req_m;
  logic [GW-1:0]        start;
  logic [GW-1:0]        gnt_inc;
  logic [GW-1:0]        win;
  logic                 hit;
  logic                 tmo;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign addr_a[gi]  = bus.s_addr[32*gi +: 32];
      assign wdata_a[gi] = bus.s_wdata[32*gi +: 32];
      assign wstrb_a[gi] = bus.s_wstrb[4*gi +: 4];
    end
  endgenerate

  assign bus.mem_valid = (state_q == S_BUSY);
  assign busy          = (state_q == S_BUSY);
  assign bus.mem_addr  = addr_a[gnt_q];
  assign bus.mem_wdata = wdata_a[gnt_q];
  assign bus.mem_wstrb = wstrb_a[gnt_q];
  assign gnt_id        = gnt_q;

  assign gnt_oh  = NUM_PORTS'(1) << gnt_q;
  assign gnt_inc = (int'(gnt_q) == NUM_PORTS - 1) ? '0 : gnt_q + 1'b1;

  // While busy the search prepares the follow-on grant, so the current owner is
  // excluded and the scan begins just after it.
  assign start = (state_q == S_BUSY) ? gnt_inc : ptr_q;
  assign req_m = (state_q == S_BUSY) ? (bus.s_valid & ~gnt_oh) : bus.s_valid;

  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int idx;
      idx = int'(start) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!hit && req_m[idx]) begin
        hit = 1'b1;
        win = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    bus.s_ready = '0;
    bus.s_rdata = bus.mem_rdata;
    timeout_err = 1'b0;
    tmo         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          gnt_d   = win;
          timer_d = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        tmo = (TIMEOUT > 0) && (timer_q == TMO_LAST) && !bus.mem_ready;
        if (bus.mem_ready || tmo) begin
          bus.s_ready = gnt_oh & bus.s_valid;
          if (tmo) begin
            bus.s_rdata = ABORT_DATA;
            timeout_err = 1'b1;
          end
          ptr_d = gnt_inc;
          if (hit) begin
            gnt_d   = win;
            timer_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
    end
  end
endmodule

// File: tb/tb_mem_rr_arb.sv
// Randomized scoreboard bench for mem_rr_arb: a transaction-level model predicts grants,
// busy cycles and completions; a separate monitor compares them against the bus.
module tb_mem_rr_arb;
  localparam int          N     = 4;
  localparam int          TMO   = 8;
  localparam logic [31:0] ABORT = 32'h0000_0000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout_err;

  mem_rr_arb_if #(.NUM_PORTS(N)) bus ();

  mem_rr_arb #(.NUM_PORTS(N), .TIMEOUT(TMO), .ABORT_DATA(ABORT)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {int cyc; int port; logic [31:0] rdata; logic tmo;} cpl_t;
  typedef struct {int cyc; int port; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} gnt_t;
  typedef struct {int cyc; logic busy;} bsy_t;
  cpl_t cq[$];
  gnt_t gq[$];
  bsy_t bq[$];

  bit   [N-1:0] act;
  bit   [N-1:0] done_m;
  logic [31:0]  a_addr  [N];
  logic [31:0]  a_wdata [N];
  logic [3:0]   a_wstrb [N];

  // Transaction-level view of the arbiter: who owns the bus, where the next
  // search begins, and how long the owner has been waiting.
  bit m_busy = 1'b0;
  int m_own  = 0;
  int m_ptr  = 0;
  int m_wait = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, actual, required);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int from);
    for (int k = 0; k < N; k++) begin
      int p;
      p = (from + k) % N;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  task automatic drive_bus();
    for (int p = 0; p < N; p++) begin
      bus.s_addr[32*p +: 32]  = a_addr[p];
      bus.s_wdata[32*p +: 32] = a_wdata[p];
      bus.s_wstrb[4*p +: 4]   = a_wstrb[p];
    end
    bus.s_valid = act;
  endtask

  task automatic push_grant(input int p);
    gnt_t g;
    g.cyc = cyc + 1; g.port = p; g.addr = a_addr[p]; g.wdata = a_wdata[p]; g.wstrb = a_wstrb[p];
    gq.push_back(g);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_own = 0; m_ptr = 0; m_wait = 0;
    act = '0; done_m = '0;
    cq.delete(); gq.delete(); bq.delete();
  endtask

  // mode 0: random ready; 1: always ready; 2: stalled, with a coin flip on the last timeout cycle
  task automatic step(input bit [N-1:0] force_m, input int pct, input int mode);
    bsy_t b;
    @(negedge clk);
    cyc++;
    for (int p = 0; p < N; p++) if (done_m[p]) act[p] = 1'b0;
    done_m = '0;
    for (int p = 0; p < N; p++) begin
      if (!act[p] && (force_m[p] || int'($urandom_range(99)) < pct)) begin
        act[p]     = 1'b1;
        a_addr[p]  = $urandom;
        a_wdata[p] = $urandom;
        a_wstrb[p] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
      end
    end
    drive_bus();
    bus.mem_rdata = $urandom;
    case (mode)
      0:       bus.mem_ready = (int'($urandom_range(99)) < 70);
      1:       bus.mem_ready = 1'b1;
      default: bus.mem_ready = (m_busy && m_wait == TMO - 1) ? ($urandom_range(1) == 1) : 1'b0;
    endcase

    b.cyc = cyc; b.busy = m_busy;
    bq.push_back(b);
    if (m_busy) begin
      bit t;
      t = (m_wait == TMO - 1) && !bus.mem_ready;
      if (bus.mem_ready || t) begin
        cpl_t c;
        int   nxt;
        logic [N-1:0] req;
        c.cyc = cyc; c.port = m_own; c.tmo = t;
        c.rdata = bus.mem_ready ? bus.mem_rdata : ABORT;
        cq.push_back(c);
        done_m[m_own] = 1'b1;
        m_ptr = (m_own + 1) % N;
        req = act;
        req[m_own] = 1'b0;
        nxt = pick(req, m_ptr);
        if (nxt >= 0) begin
          m_own = nxt; m_wait = 0;
          push_grant(nxt);
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_wait++;
      end
    end else if (act != '0) begin
      m_own = pick(act, m_ptr);
      m_busy = 1'b1; m_wait = 0;
      push_grant(m_own);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rstn && mon_en) begin
        while (bq.size() > 0 && bq[0].cyc < cyc) begin
          chk(1'b0, "busy_missed", 32'(bq[0].cyc), 32'(cyc));
          void'(bq.pop_front());
        end
        if (bq.size() > 0 && bq[0].cyc == cyc) begin
          bsy_t e;
          e = bq.pop_front();
          chk(bus.mem_valid == e.busy && busy == e.busy, "busy",
              {30'b0, busy, bus.mem_valid}, {30'b0, e.busy, e.busy});
        end

        while (gq.size() > 0 && gq[0].cyc < cyc) begin
          chk(1'b0, "grant_missed", 32'(gq[0].port), 32'(cyc));
          void'(gq.pop_front());
        end
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
          gnt_t e;
          e = gq.pop_front();
          chk(bus.mem_valid && 32'(gnt_id) == 32'(e.port), "grant_id", 32'(gnt_id), 32'(e.port));
          chk(bus.mem_addr == e.addr && bus.mem_wdata == e.wdata && bus.mem_wstrb == e.wstrb,
              "grant_fields", bus.mem_addr ^ bus.mem_wdata ^ 32'(bus.mem_wstrb), e.addr ^ e.wdata ^ 32'(e.wstrb));
        end

        chk($onehot0(bus.s_ready), "ready_onehot", 32'(bus.s_ready), 32'h0);
        while (cq.size() > 0 && cq[0].cyc < cyc) begin
          chk(1'b0, "ready_missed", 32'(cq[0].port), 32'(cyc));
          void'(cq.pop_front());
        end
        if (bus.s_ready != '0) begin
          if (cq.size() > 0 && cq[0].cyc == cyc) begin
            cpl_t e;
            logic [N-1:0] oh;
            e = cq.pop_front();
            oh = '0;
            oh[e.port] = 1'b1;
            chk(bus.s_ready == oh, "ready_port", 32'(bus.s_ready), 32'(oh));
            chk(bus.s_rdata == e.rdata, "rdata", bus.s_rdata, e.rdata);
            chk(timeout_err == e.tmo, "timeout_err", 32'(timeout_err), 32'(e.tmo));
          end else begin
            chk(1'b0, "unexpected_ready", 32'(bus.s_ready), 32'h0);
          end
        end else if (timeout_err) begin
          chk(1'b0, "stray_timeout_err", 32'(timeout_err), 32'h0);
        end
      end
    end
  end

  initial begin
    bit found;
    bit drained;
    for (int p = 0; p < N; p++) begin
      a_addr[p] = $urandom; a_wdata[p] = $urandom; a_wstrb[p] = 4'hF;
    end
    act = '1;
    drive_bus();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = $urandom;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk(bus.mem_valid == 1'b0 && busy == 1'b0, "reset_idle", {30'b0, busy, bus.mem_valid}, 32'h0);
    chk(bus.s_ready == '0 && timeout_err == 1'b0, "reset_ready", {27'b0, timeout_err, bus.s_ready}, 32'h0);
    chk(gnt_id == 2'd0, "reset_gnt_id", 32'(gnt_id), 32'h0);

    @(posedge clk);
    #2;
    model_reset();
    drive_bus();
    rstn   = 1'b1;
    mon_en = 1'b1;

    step(4'b0100, 0, 1);
    repeat (3) step('0, 0, 1);
    repeat (20) step('0, 100, 1);
    repeat (600) step('0, 30, 0);
    repeat (400) step('0, 40, 2);
    repeat (20) step(4'b0010, 0, 1);
    repeat (200) step('0, 50, 0);

    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      step('0, 40, 0);
      if (m_busy && m_own == 3) found = 1'b1;
    end
    chk(found, "find_busy_port3", 32'(found), 32'h1);
    @(posedge clk);
    #2;
    chk(bus.mem_valid && gnt_id == 2'd3, "pre_reset_busy3", {29'b0, gnt_id, bus.mem_valid}, 32'h7);
    rstn = 1'b0;
    #1;
    chk(bus.mem_valid == 1'b0 && busy == 1'b0 && bus.s_ready == '0, "async_reset",
        {26'b0, bus.s_ready, busy, bus.mem_valid}, 32'h0);
    model_reset();
    drive_bus();
    @(negedge clk);
    #3;
    rstn = 1'b1;

    step(4'b1111, 0, 1);
    repeat (100) step('0, 50, 0);
    repeat (100) step('0, 40, 2);

    drained = 1'b0;
    for (int k = 0; k < 400 && !drained; k++) begin
      step('0, 0, 0);
      if (!m_busy && act == '0 && done_m == '0) drained = 1'b1;
    end
    chk(drained, "drain", 32'(drained), 32'h1);
    repeat (3) step('0, 0, 0);
    chk(cq.size() == 0 && gq.size() == 0, "queues_empty", 32'(cq.size() + gq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
